count_uart_tx: RTL and testbench
================================

COUNT_UART_TX -- requirements
Module: count_uart_tx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 16, giving the clock cycles per UART bit; legal values are 4..65535.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all sequential logic is on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port count, input, 16 bits: the value from the upstream 16-bit counter, sampled only when a request is accepted.
REQ-005 The module SHALL have port send, input, 1 bit: transmit request, level-sensitive, honoured only in IDLE.
REQ-006 The module SHALL have port busy, output, 1 bit: high while a 2-byte transfer is in progress.
REQ-007 The module SHALL have port done, output, 1 bit: single-cycle pulse at transfer completion.
REQ-008 The module SHALL have port tx, output, 1 bit: UART serial line, 8N1, idle high; tx is driven from a register (no glitches).

Function
REQ-009 The FSM SHALL have states IDLE, START, DATA, STOP, plus a 1-bit byte index (0 = low byte, 1 = high byte).
REQ-010 In IDLE with send=1 at a rising edge, the block SHALL capture count into a 16-bit holding register, set busy=1 and enter START with byte index 0 on that edge.
REQ-011 tx SHALL go low on the same edge that enters START, giving one cycle of latency from send sampled to start-bit drive.
REQ-012 Each of the start, data and stop bits SHALL hold tx stable for exactly CLKS_PER_BIT cycles, timed by a bit-period counter that reloads on every bit boundary.
REQ-013 DATA SHALL shift out 8 bits, LSB first: the captured bits [7:0] for byte 0, then bits [15:8] for byte 1.
REQ-014 STOP SHALL drive tx=1; at the end of byte 0's stop bit the FSM SHALL go to START for byte 1 with no extra idle cycles.
REQ-015 At the end of byte 1's stop bit the FSM SHALL return to IDLE, with busy=0 and done=1 for exactly that one cycle.
REQ-016 A full transfer SHALL take exactly 20*CLKS_PER_BIT cycles from START entry to IDLE re-entry.
REQ-017 send SHALL be ignored while busy=1; no queuing, no truncation and no restart of the active transfer.
REQ-018 Changes on count while busy=1 SHALL NOT affect the transmitted bytes.
REQ-019 If send=1 in the IDLE cycle where done=1, a new transfer SHALL be accepted on that edge, so consecutive frames are separated by exactly one tx-high idle cycle.
REQ-020 Holding send=1 continuously SHALL produce back-to-back transfers, each capturing count afresh.
REQ-021 The bit-period counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL NOT wrap within a bit.

Reset
REQ-022 While reset=0, the block SHALL asynchronously force the state to IDLE, tx=1, busy=0, done=0, and clear the holding register, bit counter, bit index and byte index to 0.
REQ-023 A reset asserted mid-transfer SHALL abort the transfer immediately with no done pulse; after release, the block SHALL sit idle until a new send.
REQ-024 After reset deasserts, the first send SHALL be accepted at the first rising edge where reset=1.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-025 Directed scenarios SHALL be:
- count=16'h1234, send pulse 1 cycle -> tx shows start, 0x34 LSB-first, stop, start, 0x12, stop, each bit 4 cycles; busy high for 80 cycles; done=1 for 1 cycle.
- count changes to 16'hABCD 10 cycles into a transfer of 16'h0001 -> bytes 0x01, 0x00 are sent.
- send pulsed again at cycle 30 of an active transfer -> ignored, busy stays high, only one done.
- reset=0 at cycle 45 of a transfer -> tx=1 and busy=0 immediately, no done; a following send of 16'hFFFF is sent correctly.
- send held high with count=16'h00FF then 16'hFF00 -> two frames separated by exactly 1 idle-high cycle, bytes FF,00 then 00,FF.
- CLKS_PER_BIT=16, count=16'h5A5A -> each bit lasts 16 cycles and the total transfer is 320 cycles.

Source files
------------

// File: rtl/count_uart_tx.sv
// Serialises a captured 16-bit counter value as two 8N1 UART bytes, low byte first.
// A single bit-period down-counter paces start, data and stop bits alike.
module count_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] count,
    input  logic        send,
    output logic        busy,
    output logic        done,
    output logic        tx
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [15:0]   hold, hold_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic          byte_idx, byte_idx_nx;
    logic          tx_nx, busy_nx, done_nx;
    logic [7:0]    cur_byte;
    logic          bit_end;

    assign cur_byte = byte_idx ? hold[15:8] : hold[7:0];
    assign bit_end  = (cnt == '0);

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            hold     <= '0;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            hold     <= hold_nx;
            cnt      <= cnt_nx;
            bit_idx  <= bit_idx_nx;
            byte_idx <= byte_idx_nx;
            tx       <= tx_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end

    // Next-state and next-output logic; tx is computed one edge ahead so it comes from a flop
    always_comb begin
        state_nx    = state;
        hold_nx     = hold;
        cnt_nx      = cnt;
        bit_idx_nx  = bit_idx;
        byte_idx_nx = byte_idx;
        tx_nx       = tx;
        busy_nx     = busy;
        done_nx     = 1'b0;

        if (state != IDLE) begin
            cnt_nx = bit_end ? RELOAD : cnt - CW'(1);
        end

        case (state)
            IDLE: begin
                if (send) begin
                    hold_nx     = count;
                    state_nx    = START;
                    tx_nx       = 1'b0;
                    busy_nx     = 1'b1;
                    cnt_nx      = RELOAD;
                    bit_idx_nx  = 3'd0;
                    byte_idx_nx = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nx   = DATA;
                    bit_idx_nx = 3'd0;
                    tx_nx      = cur_byte[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                        tx_nx    = 1'b1;
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                        tx_nx      = cur_byte[bit_idx + 3'd1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!byte_idx) begin
                        state_nx    = START;
                        byte_idx_nx = 1'b1;
                        tx_nx       = 1'b0;
                    end else begin
                        state_nx    = IDLE;
                        byte_idx_nx = 1'b0;
                        tx_nx       = 1'b1;
                        busy_nx     = 1'b0;
                        done_nx     = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_count_uart_tx.sv
// Directed bench for count_uart_tx: one instance at 4 clocks/bit, one at 16 clocks/bit.
module tb_count_uart_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] count = 16'h0000;
    logic        send4 = 1'b0;
    logic        send16 = 1'b0;
    logic        busy4, done4, tx4;
    logic        busy16, done16, tx16;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    count_uart_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .reset(reset), .count(count), .send(send4),
        .busy(busy4), .done(done4), .tx(tx4)
    );

    count_uart_tx #(.CLKS_PER_BIT(16)) dut16 (
        .clk(clk), .reset(reset), .count(count), .send(send16),
        .busy(busy16), .done(done16), .tx(tx16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_send(input int s, input logic v);
        if (s == 1) send16 = v;
        else        send4  = v;
    endtask

    // Entered just after the accepting edge; walks the whole frame cycle by cycle
    // and ends just after the edge that returns to IDLE (the done cycle).
    task automatic frame(input int s, input logic [15:0] val, input int chg_at, input int send_at);
        int c;
        logic [19:0] bits;
        logic t, b, d;
        c    = (s == 1) ? 16 : 4;
        bits = {1'b1, val[15:8], 1'b0, 1'b1, val[7:0], 1'b0};
        for (int i = 0; i < 20 * c; i++) begin
            t = (s == 1) ? tx16 : tx4;
            b = (s == 1) ? busy16 : busy4;
            d = (s == 1) ? done16 : done4;
            check($sformatf("tx[%0d]", i), 32'(t), 32'(bits[i / c]));
            check($sformatf("busy[%0d]", i), 32'(b), 32'd1);
            check($sformatf("done[%0d]", i), 32'(d), 32'd0);
            if (i == chg_at) count = 16'hABCD;
            if (i == send_at) set_send(s, 1'b1);
            if (send_at >= 0 && i == send_at + 1) set_send(s, 1'b0);
            tick();
        end
        t = (s == 1) ? tx16 : tx4;
        b = (s == 1) ? busy16 : busy4;
        d = (s == 1) ? done16 : done4;
        check("end_done", 32'(d), 32'd1);
        check("end_busy", 32'(b), 32'd0);
        check("end_tx", 32'(t), 32'd1);
    endtask

    task automatic idle_after(input int s, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("idle_done", 32'((s == 1) ? done16 : done4), 32'd0);
            check("idle_busy", 32'((s == 1) ? busy16 : busy4), 32'd0);
            check("idle_tx", 32'((s == 1) ? tx16 : tx4), 32'd1);
        end
    endtask

    initial begin
        tick();
        tick();
        check("rst_tx4", 32'(tx4), 32'd1);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_done4", 32'(done4), 32'd0);
        check("rst_tx16", 32'(tx16), 32'd1);
        check("rst_busy16", 32'(busy16), 32'd0);

        // Basic frame; first send accepted at the first edge after reset release
        reset = 1'b1;
        count = 16'h1234;
        send4 = 1'b1;
        tick();
        send4 = 1'b0;
        frame(0, 16'h1234, -1, -1);
        idle_after(0, 3);

        // count changes mid-transfer are not transmitted
        count = 16'h0001;
        send4 = 1'b1;
        tick();
        send4 = 1'b0;
        frame(0, 16'h0001, 10, -1);
        idle_after(0, 3);

        // A second send pulse mid-transfer is ignored and not queued
        count = 16'hC3A5;
        send4 = 1'b1;
        tick();
        send4 = 1'b0;
        frame(0, 16'hC3A5, -1, 30);
        idle_after(0, 6);

        // Reset mid-transfer aborts immediately without a done pulse
        count = 16'h1234;
        send4 = 1'b1;
        tick();
        send4 = 1'b0;
        repeat (45) tick();
        reset = 1'b0;
        #1;
        check("abort_tx", 32'(tx4), 32'd1);
        check("abort_busy", 32'(busy4), 32'd0);
        check("abort_done", 32'(done4), 32'd0);
        tick();
        reset = 1'b1;
        idle_after(0, 4);
        count = 16'hFFFF;
        send4 = 1'b1;
        tick();
        send4 = 1'b0;
        frame(0, 16'hFFFF, -1, -1);
        idle_after(0, 2);

        // send held high: back-to-back frames with one idle-high cycle between them
        count = 16'h00FF;
        send4 = 1'b1;
        tick();
        frame(0, 16'h00FF, -1, -1);
        count = 16'hFF00;
        tick();
        frame(0, 16'hFF00, -1, -1);
        send4 = 1'b0;
        idle_after(0, 3);

        // 16 clocks per bit: 320-cycle transfer
        count = 16'h5A5A;
        send16 = 1'b1;
        tick();
        send16 = 1'b0;
        frame(1, 16'h5A5A, -1, -1);
        idle_after(1, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
